// File: rtl/rs_dispatch_sched_if.sv
// Issue, CDB, flush and dispatch signals of one reservation station.
// master = issue stage / CDB / functional unit side, slave = the scheduler.
interface rs_dispatch_sched_if #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FUNC_W  = 4
);
    localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

    logic              alloc_valid;
    logic              alloc_ready;
    logic [FUNC_W-1:0] alloc_func;
    logic [TAG_W-1:0]  alloc_rob;
    logic              alloc_rs1_b;
    logic              alloc_rs2_b;
    logic [DATA_W-1:0] alloc_rs1;
    logic [DATA_W-1:0] alloc_rs2;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [FUNC_W-1:0] disp_func;
    logic [DATA_W-1:0] disp_op1;
    logic [DATA_W-1:0] disp_op2;
    logic [TAG_W-1:0]  disp_rob;
    logic [OCC_W-1:0]  occupancy;
    logic              full;
    logic              empty;

    modport master (
        output alloc_valid, alloc_func, alloc_rob, alloc_rs1_b, alloc_rs2_b, alloc_rs1,
               alloc_rs2, cdb_valid, cdb_tag, cdb_data, flush, disp_ready,
        input  alloc_ready, disp_valid, disp_func, disp_op1, disp_op2, disp_rob, occupancy,
               full, empty
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rob, alloc_rs1_b, alloc_rs2_b, alloc_rs1,
               alloc_rs2, cdb_valid, cdb_tag, cdb_data, flush, disp_ready,
        output alloc_ready, disp_valid, disp_func, disp_op1, disp_op2, disp_rob, occupancy,
               full, empty
    );
endinterface

// File: rtl/rs_dispatch_sched.sv
// Reservation station: CDB tag wake-up, round-robin select, locked valid/ready dispatch.
// Optional same-cycle CDB bypass on allocation is enabled by defining RS_CDB_BYPASS_EN.
module rs_dispatch_sched #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FUNC_W  = 4
) (
    input logic                clk2,
    input logic                rst,
    rs_dispatch_sched_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] rdy1_q;
    logic [ENTRIES-1:0] rdy2_q;
    logic [FUNC_W-1:0]  func_q  [ENTRIES];
    logic [TAG_W-1:0]   rob_q   [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   lock_idx_q;
    logic               lock_valid_q;

    logic [ENTRIES-1:0] eligible;
    logic               any_elig;
    logic [OCC_W-1:0]   occ;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   search_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               alloc_fire;
    logic               disp_fire;
    logic               a1_rdy;
    logic               a2_rdy;
    logic [DATA_W-1:0]  a1_data;
    logic [DATA_W-1:0]  a2_data;

    // Occupancy and lowest free slot; descending scan lets the lowest index win.
    always_comb begin
        occ      = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            occ = occ + OCC_W'(valid_q[i]);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        logic [IDX_W-1:0] idx;
        eligible   = valid_q & rdy1_q & rdy2_q;
        any_elig   = |eligible;
        search_idx = rr_ptr_q;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            idx = rr_ptr_q + IDX_W'(k);
            if (eligible[idx]) search_idx = idx;
        end
    end

    always_comb begin
        a1_rdy  = bus.alloc_rs1_b;
        a1_data = bus.alloc_rs1;
        a2_rdy  = bus.alloc_rs2_b;
        a2_data = bus.alloc_rs2;
`ifdef RS_CDB_BYPASS_EN
        if (!bus.alloc_rs1_b && bus.cdb_valid && bus.alloc_rs1[TAG_W-1:0] == bus.cdb_tag) begin
            a1_rdy  = 1'b1;
            a1_data = bus.cdb_data;
        end
        if (!bus.alloc_rs2_b && bus.cdb_valid && bus.alloc_rs2[TAG_W-1:0] == bus.cdb_tag) begin
            a2_rdy  = 1'b1;
            a2_data = bus.cdb_data;
        end
`endif
    end

    // A locked entry cannot lose readiness, so the lock alone keeps the offer alive.
    assign sel_idx        = lock_valid_q ? lock_idx_q : search_idx;
    assign bus.disp_valid = (lock_valid_q || any_elig) && !bus.flush;
    assign bus.disp_func  = bus.disp_valid ? func_q[sel_idx]  : '0;
    assign bus.disp_op1   = bus.disp_valid ? data1_q[sel_idx] : '0;
    assign bus.disp_op2   = bus.disp_valid ? data2_q[sel_idx] : '0;
    assign bus.disp_rob   = bus.disp_valid ? rob_q[sel_idx]   : '0;

    assign bus.occupancy   = occ;
    assign bus.full        = (occ == OCC_W'(ENTRIES));
    assign bus.empty       = (occ == '0);
    assign bus.alloc_ready = !bus.full;

    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
    assign disp_fire  = bus.disp_valid && bus.disp_ready;

    always_ff @(posedge clk2) begin
        if (rst || bus.flush) begin
            valid_q      <= '0;
            lock_valid_q <= 1'b0;
            if (rst) rr_ptr_q <= '0;
        end else begin
            if (bus.cdb_valid) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (valid_q[i] && !rdy1_q[i] && tag1_q[i] == bus.cdb_tag) begin
                        rdy1_q[i]  <= 1'b1;
                        data1_q[i] <= bus.cdb_data;
                    end
                    if (valid_q[i] && !rdy2_q[i] && tag2_q[i] == bus.cdb_tag) begin
                        rdy2_q[i]  <= 1'b1;
                        data2_q[i] <= bus.cdb_data;
                    end
                end
            end
            if (alloc_fire) begin
                valid_q[free_idx] <= 1'b1;
                func_q[free_idx]  <= bus.alloc_func;
                rob_q[free_idx]   <= bus.alloc_rob;
                rdy1_q[free_idx]  <= a1_rdy;
                rdy2_q[free_idx]  <= a2_rdy;
                data1_q[free_idx] <= a1_data;
                data2_q[free_idx] <= a2_data;
                tag1_q[free_idx]  <= bus.alloc_rs1[TAG_W-1:0];
                tag2_q[free_idx]  <= bus.alloc_rs2[TAG_W-1:0];
            end
            if (disp_fire) begin
                valid_q[sel_idx] <= 1'b0;
                rr_ptr_q         <= sel_idx + IDX_W'(1);
                lock_valid_q     <= 1'b0;
            end else if (bus.disp_valid) begin
                lock_valid_q <= 1'b1;
                lock_idx_q   <= sel_idx;
            end
        end
    end
endmodule

// File: tb/tb_rs_dispatch_sched.sv
// Directed plus randomized bench for rs_dispatch_sched, compared every cycle against an
// entry-table reference model evaluated from the scheduling rules.
module tb_rs_dispatch_sched;
    localparam int E  = 4;
    localparam int TW = 3;
    localparam int DW = 16;
    localparam int FW = 4;

    logic clk2 = 1'b0;
    logic rst;

    rs_dispatch_sched_if #(.ENTRIES(E), .TAG_W(TW), .DATA_W(DW), .FUNC_W(FW)) bus ();

    rs_dispatch_sched #(
        .ENTRIES(E),
        .TAG_W  (TW),
        .DATA_W (DW),
        .FUNC_W (FW)
    ) dut (
        .clk2(clk2),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk2 = ~clk2;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a table of entries plus pointer and lock.
    bit            m_v  [E];
    bit            m_r1 [E];
    bit            m_r2 [E];
    logic [DW-1:0] m_d1 [E];
    logic [DW-1:0] m_d2 [E];
    logic [TW-1:0] m_t1 [E];
    logic [TW-1:0] m_t2 [E];
    logic [TW-1:0] m_rob[E];
    logic [FW-1:0] m_fn [E];
    int            m_rr;
    int            m_lock;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < E; i++) c += int'(m_v[i]);
        return c;
    endfunction

    function automatic int m_pick();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < E; k++) begin
            int j = (m_rr + k) % E;
            if (m_v[j] && m_r1[j] && m_r2[j]) return j;
        end
        return -1;
    endfunction

    task automatic compare_outputs();
        int s   = m_pick();
        int occ = m_count();
        int si  = (s < 0) ? 0 : s;
        bit dv  = (s >= 0) && !bus.flush;
        check_eq("occupancy", 32'(bus.occupancy), 32'(occ));
        check_eq("full", 32'(bus.full), 32'(occ == E));
        check_eq("empty", 32'(bus.empty), 32'(occ == 0));
        check_eq("alloc_ready", 32'(bus.alloc_ready), 32'(occ < E));
        check_eq("disp_valid", 32'(bus.disp_valid), 32'(dv));
        check_eq("disp_func", 32'(bus.disp_func), dv ? 32'(m_fn[si]) : 32'(0));
        check_eq("disp_op1", 32'(bus.disp_op1), dv ? 32'(m_d1[si]) : 32'(0));
        check_eq("disp_op2", 32'(bus.disp_op2), dv ? 32'(m_d2[si]) : 32'(0));
        check_eq("disp_rob", 32'(bus.disp_rob), dv ? 32'(m_rob[si]) : 32'(0));
    endtask

    task automatic model_update();
        int s;
        int fr;
        bit dv;
        bit afire;
        if (rst || bus.flush) begin
            for (int i = 0; i < E; i++) m_v[i] = 1'b0;
            m_lock = -1;
            if (rst) m_rr = 0;
            return;
        end
        s     = m_pick();
        dv    = (s >= 0);
        afire = bus.alloc_valid && (m_count() < E);
        fr    = -1;
        for (int i = E - 1; i >= 0; i--) if (!m_v[i]) fr = i;
        if (bus.cdb_valid) begin
            for (int i = 0; i < E; i++) begin
                if (m_v[i] && !m_r1[i] && m_t1[i] == bus.cdb_tag) begin
                    m_r1[i] = 1'b1;
                    m_d1[i] = bus.cdb_data;
                end
                if (m_v[i] && !m_r2[i] && m_t2[i] == bus.cdb_tag) begin
                    m_r2[i] = 1'b1;
                    m_d2[i] = bus.cdb_data;
                end
            end
        end
        if (afire) begin
            m_v[fr]   = 1'b1;
            m_fn[fr]  = bus.alloc_func;
            m_rob[fr] = bus.alloc_rob;
            m_r1[fr]  = bus.alloc_rs1_b;
            m_r2[fr]  = bus.alloc_rs2_b;
            m_d1[fr]  = bus.alloc_rs1;
            m_d2[fr]  = bus.alloc_rs2;
            m_t1[fr]  = bus.alloc_rs1[TW-1:0];
            m_t2[fr]  = bus.alloc_rs2[TW-1:0];
`ifdef RS_CDB_BYPASS_EN
            if (!bus.alloc_rs1_b && bus.cdb_valid && bus.alloc_rs1[TW-1:0] == bus.cdb_tag) begin
                m_r1[fr] = 1'b1;
                m_d1[fr] = bus.cdb_data;
            end
            if (!bus.alloc_rs2_b && bus.cdb_valid && bus.alloc_rs2[TW-1:0] == bus.cdb_tag) begin
                m_r2[fr] = 1'b1;
                m_d2[fr] = bus.cdb_data;
            end
`endif
        end
        if (dv && bus.disp_ready) begin
            m_v[s] = 1'b0;
            m_rr   = (s + 1) % E;
            m_lock = -1;
        end else if (dv) begin
            m_lock = s;
        end
    endtask

    task automatic cyc();
        @(negedge clk2);
        compare_outputs();
        @(posedge clk2);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst             = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_func  = '0;
        bus.alloc_rob   = '0;
        bus.alloc_rs1_b = 1'b1;
        bus.alloc_rs2_b = 1'b1;
        bus.alloc_rs1   = '0;
        bus.alloc_rs2   = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.flush       = 1'b0;
        bus.disp_ready  = 1'b0;
    endtask

    task automatic set_alloc(input logic [FW-1:0] f, input logic [TW-1:0] rob, input bit b1,
                             input logic [DW-1:0] v1, input bit b2, input logic [DW-1:0] v2);
        bus.alloc_valid = 1'b1;
        bus.alloc_func  = f;
        bus.alloc_rob   = rob;
        bus.alloc_rs1_b = b1;
        bus.alloc_rs1   = v1;
        bus.alloc_rs2_b = b2;
        bus.alloc_rs2   = v2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_lock   = -1;
        m_rr     = 0;
        idle();
        rst = 1'b1;
        @(posedge clk2);
        model_update();
        #1;
        cyc();
        check_eq("rst_empty", 32'(bus.empty), 32'(1));
        check_eq("rst_alloc_ready", 32'(bus.alloc_ready), 32'(1));
        check_eq("rst_disp_valid", 32'(bus.disp_valid), 32'(0));
        rst = 1'b0;

        // Fill with four ready entries under backpressure, then drain in order.
        for (int k = 0; k < E; k++) begin
            set_alloc(FW'(k + 1), TW'(k), 1'b1, DW'(k * 16 + 1), 1'b1, DW'(k + 2));
            cyc();
        end
        set_alloc(4'hF, 3'd7, 1'b1, 16'h7777, 1'b1, 16'h7777);
        check_eq("full_set", 32'(bus.full), 32'(1));
        check_eq("full_alloc_ready", 32'(bus.alloc_ready), 32'(0));
        cyc();
        bus.alloc_valid = 1'b0;
        bus.disp_ready  = 1'b1;
        for (int k = 0; k < E; k++) begin
            check_eq("drain_rob", 32'(bus.disp_rob), 32'(k));
            cyc();
        end
        check_eq("drain_empty", 32'(bus.empty), 32'(1));

        // CDB wake-up of rs1.
        idle();
        set_alloc(4'h5, 3'd4, 1'b0, 16'h0003, 1'b1, 16'h0005);
        cyc();
        bus.alloc_valid = 1'b0;
        check_eq("wake_wait", 32'(bus.disp_valid), 32'(0));
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd3;
        bus.cdb_data  = 16'h00AA;
        cyc();
        bus.cdb_valid = 1'b0;
        check_eq("wake_valid", 32'(bus.disp_valid), 32'(1));
        check_eq("wake_op1", 32'(bus.disp_op1), 32'h00AA);
        check_eq("wake_op2", 32'(bus.disp_op2), 32'h0005);
        bus.disp_ready = 1'b1;
        cyc();
        bus.disp_ready = 1'b0;

        // Lock: entry 2 offered with rr_ptr=1 while entry 1 wakes up behind it.
        set_alloc(4'h1, 3'd0, 1'b0, 16'h0007, 1'b1, 16'h0001);
        cyc();
        set_alloc(4'h2, 3'd1, 1'b0, 16'h0006, 1'b1, 16'h0002);
        cyc();
        set_alloc(4'h3, 3'd2, 1'b1, 16'h0033, 1'b1, 16'h0003);
        cyc();
        bus.alloc_valid = 1'b0;
        check_eq("lock_first", 32'(bus.disp_rob), 32'(2));
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd6;
        bus.cdb_data  = 16'h0666;
        cyc();
        bus.cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("lock_hold", 32'(bus.disp_rob), 32'(2));
            cyc();
        end
        bus.disp_ready = 1'b1;
        cyc();
        check_eq("lock_next", 32'(bus.disp_rob), 32'(1));
        cyc();
        bus.disp_ready = 1'b0;

        // Flush with a concurrent allocation while full.
        for (int k = 0; k < 3; k++) begin
            set_alloc(4'h8, TW'(k + 4), 1'b1, 16'h0101, 1'b1, 16'h0202);
            cyc();
        end
        check_eq("flush_full", 32'(bus.full), 32'(1));
        bus.flush = 1'b1;
        set_alloc(4'h9, 3'd7, 1'b1, 16'h0909, 1'b1, 16'h0909);
        #1;
        check_eq("flush_disp_valid", 32'(bus.disp_valid), 32'(0));
        cyc();
        idle();
        check_eq("flush_occupancy", 32'(bus.occupancy), 32'(0));

        // Allocation racing a CDB broadcast of its own source tag.
        set_alloc(4'h3, 3'd5, 1'b1, 16'h0011, 1'b0, 16'h0005);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd5;
        bus.cdb_data  = 16'h1234;
        cyc();
        idle();
`ifdef RS_CDB_BYPASS_EN
        check_eq("bypass_valid", 32'(bus.disp_valid), 32'(1));
        check_eq("bypass_op2", 32'(bus.disp_op2), 32'h1234);
`else
        check_eq("nobypass_valid", 32'(bus.disp_valid), 32'(0));
`endif
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            bus.alloc_valid = ($urandom_range(99) < 60);
            bus.alloc_func  = FW'($urandom);
            bus.alloc_rob   = TW'($urandom);
            bus.alloc_rs1_b = ($urandom_range(99) < 50);
            bus.alloc_rs2_b = ($urandom_range(99) < 50);
            bus.alloc_rs1   = DW'($urandom);
            bus.alloc_rs2   = DW'($urandom);
            bus.cdb_valid   = ($urandom_range(99) < 40);
            bus.cdb_tag     = TW'($urandom);
            bus.cdb_data    = DW'($urandom);
            bus.disp_ready  = ($urandom_range(99) < 60);
            bus.flush       = ($urandom_range(99) < 2);
            rst             = ($urandom_range(99) < 1);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
